// File: rtl/alu_pkg.sv
// Shared ALU op-codes, writeback state encoding and op classification.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        MUL  = 3'b010,
        DIV  = 3'b011,
        AND  = 3'b100,
        OR   = 3'b101,
        XOR  = 3'b110,
        UADD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WR1  = 2'b01,
        WR2  = 2'b10
    } wb_state_e;

    // mul and div produce a secondary result R that needs a second write
    function automatic logic is_dual(input logic [OP_W-1:0] op);
        return (op == OP_W'(MUL)) || (op == OP_W'(DIV));
    endfunction

endpackage

// File: rtl/alu_wb_fwd.sv
// Forwarding compare: matches a read address against the write on the port
// this cycle and the R write still pending behind it; current write wins.
module alu_wb_fwd #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RADDR_W = 4
) (
    input  logic [RADDR_W-1:0] raddr,
    input  logic               cur_en,
    input  logic [RADDR_W-1:0] cur_addr,
    input  logic [DATA_W-1:0]  cur_data,
    input  logic               pend_en,
    input  logic [RADDR_W-1:0] pend_addr,
    input  logic [DATA_W-1:0]  pend_data,
    output logic               hit_c,
    output logic [DATA_W-1:0]  data_c
);

    logic cur_hit;
    logic pend_hit;

    // register 0 never forwards; the in-flight write has priority over the pending one
    always_comb begin
        cur_hit  = cur_en  && (cur_addr  == raddr) && (raddr != '0);
        pend_hit = pend_en && (pend_addr == raddr) && (raddr != '0);
        hit_c    = cur_hit || pend_hit;
        data_c   = '0;
        if (cur_hit) begin
            data_c = cur_data;
        end else if (pend_hit) begin
            data_c = pend_data;
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: turns accepted ALU results into register-file writes,
// two writes (Out then R) for mul/div. Optional forwarding port under WB_FWD_EN.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int unsigned         DATA_W  = 16,
    parameter int unsigned         RADDR_W = 4,
    parameter logic [RADDR_W-1:0]  R_REG   = RADDR_W'(4'hF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]  in_out,
    input  logic [DATA_W-1:0]  in_r,
    input  logic               in_sign,
    output logic               wr_en,
    output logic [RADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic               sign_flag
`ifdef WB_FWD_EN
    ,
    input  logic [RADDR_W-1:0] fwd_raddr,
    output logic               fwd_hit,
    output logic [DATA_W-1:0]  fwd_data
`endif
);

    wb_state_e          state_q,     state_d;
    logic               in_ready_q,  in_ready_d;
    logic               wr_en_q,     wr_en_d;
    logic [RADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q,   wr_data_d;
    logic               sign_flag_q, sign_flag_d;
    logic [DATA_W-1:0]  r_q,         r_d;
    logic               dual_q,      dual_d;
    logic               accept;
    logic               load_new;

    // next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b1;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        sign_flag_d = sign_flag_q;
        r_d         = r_q;
        dual_d      = dual_q;
        accept      = in_valid && in_ready_q;
        load_new    = 1'b0;

        if (accept) begin
            sign_flag_d = in_sign;
        end

        case (state_q)
            WR1: begin
                if (dual_q) begin
                    state_d   = WR2;
                    wr_en_d   = (R_REG != '0);
                    wr_addr_d = R_REG;
                    wr_data_d = r_q;
                end else if (accept) begin
                    load_new = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                if (accept) begin
                    load_new = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        // a newly accepted result always starts with its Out write
        if (load_new) begin
            state_d    = WR1;
            wr_en_d    = (in_rd != '0);
            wr_addr_d  = in_rd;
            wr_data_d  = in_out;
            r_d        = in_r;
            dual_d     = is_dual(in_op);
            in_ready_d = !is_dual(in_op);
        end
    end

    // state and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            sign_flag_q <= 1'b0;
            r_q         <= '0;
            dual_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            sign_flag_q <= sign_flag_d;
            r_q         <= r_d;
            dual_q      <= dual_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign sign_flag = sign_flag_q;

`ifdef WB_FWD_EN
    logic pend_en;

    // R write is pending while a dual op sits in WR1
    always_comb begin
        pend_en = (state_q == WR1) && dual_q;
    end

    alu_wb_fwd #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd (
        .raddr     (fwd_raddr),
        .cur_en    (wr_en_q),
        .cur_addr  (wr_addr_q),
        .cur_data  (wr_data_q),
        .pend_en   (pend_en),
        .pend_addr (R_REG),
        .pend_data (r_q),
        .hit_c     (fwd_hit),
        .data_c    (fwd_data)
    );
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback; forwarding checks build with WB_FWD_EN.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_rd;
    logic [15:0] in_out;
    logic [15:0] in_r;
    logic        in_sign;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        sign_flag;
`ifdef WB_FWD_EN
    logic [3:0]  fwd_raddr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_out    (in_out),
        .in_r      (in_r),
        .in_sign   (in_sign),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .sign_flag (sign_flag)
`ifdef WB_FWD_EN
        ,
        .fwd_raddr (fwd_raddr),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] rd,
                         input logic [15:0] o, input logic [15:0] r, input logic s);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_out   = o;
        in_r     = r;
        in_sign  = s;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [3:0] a,
                            input logic [15:0] d, input logic rdy);
        chk({tag, "_en"},   32'(wr_en),    32'(en));
        chk({tag, "_addr"}, 32'(wr_addr),  32'(a));
        chk({tag, "_data"}, 32'(wr_data),  32'(d));
        chk({tag, "_rdy"},  32'(in_ready), 32'(rdy));
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_op    = 3'b000;
        in_rd    = 4'h0;
        in_out   = 16'h0;
        in_r     = 16'h0;
        in_sign  = 1'b0;
`ifdef WB_FWD_EN
        fwd_raddr = 4'h0;
`endif
        tick();
        tick();
        check_wr("reset", 1'b0, 4'h0, 16'h0, 1'b1);
        chk("reset_sign", 32'(sign_flag), 32'h0);
        rst = 1'b0;
        tick();

        // single-write add
        drive(3'b000, 4'h3, 16'h0004, 16'h0000, 1'b1);
        tick();
        in_valid = 1'b0;
        in_sign  = 1'b0;
        check_wr("add_wr1", 1'b1, 4'h3, 16'h0004, 1'b1);
        chk("add_sign", 32'(sign_flag), 32'h1);
        tick();
        check_wr("add_idle", 1'b0, 4'h3, 16'h0004, 1'b1);
        chk("idle_sign_hold", 32'(sign_flag), 32'h1);

        // mul: Out then R to register F
        drive(3'b010, 4'h5, 16'h0001, 16'hFFFE, 1'b0);
        tick();
        in_valid = 1'b0;
        check_wr("mul_wr1", 1'b1, 4'h5, 16'h0001, 1'b0);
        tick();
        check_wr("mul_wr2", 1'b1, 4'hF, 16'hFFFE, 1'b1);
        tick();
        chk("mul_idle_en", 32'(wr_en), 32'h0);

        // div followed by a held-valid op 100: stalled then accepted
        drive(3'b011, 4'h2, 16'h0004, 16'h0001, 1'b0);
        tick();
        drive(3'b100, 4'h7, 16'h0009, 16'h0003, 1'b1);
        check_wr("div_wr1", 1'b1, 4'h2, 16'h0004, 1'b0);
        tick();
        check_wr("div_wr2", 1'b1, 4'hF, 16'h0001, 1'b1);
        chk("div_stall_sign", 32'(sign_flag), 32'h0);
        tick();
        in_valid = 1'b0;
        check_wr("b2b_wr1", 1'b1, 4'h7, 16'h0009, 1'b1);
        chk("b2b_sign", 32'(sign_flag), 32'h1);
        tick();
        chk("b2b_idle_en", 32'(wr_en), 32'h0);

        // rd = 0 suppresses the write but still updates sign
        drive(3'b101, 4'h0, 16'h0005, 16'h0000, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("rd0_en", 32'(wr_en), 32'h0);
        chk("rd0_sign", 32'(sign_flag), 32'h0);
        drive(3'b110, 4'h0, 16'h0006, 16'h0000, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("rd0_en2", 32'(wr_en), 32'h0);
        chk("rd0_sign2", 32'(sign_flag), 32'h1);
        tick();

        // reset during WR1 of a mul discards the R write
        drive(3'b010, 4'h6, 16'h0011, 16'h0022, 1'b1);
        tick();
        in_valid = 1'b0;
        check_wr("rstmul_wr1", 1'b1, 4'h6, 16'h0011, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_wr("rstmul_rst", 1'b0, 4'h0, 16'h0000, 1'b1);
        chk("rstmul_sign", 32'(sign_flag), 32'h0);
        tick();
        check_wr("rstmul_noR", 1'b0, 4'h0, 16'h0000, 1'b1);

`ifdef WB_FWD_EN
        // forwarding from the current write and the pending R write
        drive(3'b011, 4'h4, 16'h0008, 16'h0001, 1'b0);
        tick();
        in_valid  = 1'b0;
        fwd_raddr = 4'h4;
        #1;
        chk("fwd_wr1_hit", 32'(fwd_hit), 32'h1);
        chk("fwd_wr1_data", 32'(fwd_data), 32'h0008);
        fwd_raddr = 4'hF;
        #1;
        chk("fwd_pend_hit", 32'(fwd_hit), 32'h1);
        chk("fwd_pend_data", 32'(fwd_data), 32'h0001);
        tick();
        fwd_raddr = 4'hF;
        #1;
        chk("fwd_wr2_hit", 32'(fwd_hit), 32'h1);
        chk("fwd_wr2_data", 32'(fwd_data), 32'h0001);
        fwd_raddr = 4'h0;
        #1;
        chk("fwd_r0_hit", 32'(fwd_hit), 32'h0);
        tick();
        fwd_raddr = 4'hF;
        #1;
        chk("fwd_idle_hit", 32'(fwd_hit), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter DATA_W, default 16, ALU result width.
REQ-002 SHALL have parameter RADDR_W, default 4, register-file address width.
REQ-003 SHALL have parameter R_REG, default 4'hF, register receiving the secondary result R (mul high half / div remainder).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  ALU result present.
REQ-007 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-008 SHALL have port in_op  input  3  ALU Operation code of the result.
REQ-009 SHALL have port in_rd  input  RADDR_W  destination register for Out.
REQ-010 SHALL have port in_out  input  DATA_W  ALU Out.
REQ-011 SHALL have port in_r  input  DATA_W  ALU R.
REQ-012 SHALL have port in_sign  input  1  ALU signFlag.
REQ-013 SHALL have port wr_en  output  1  register-file write strobe.
REQ-014 SHALL have port wr_addr  output  RADDR_W  write address.
REQ-015 SHALL have port wr_data  output  DATA_W  write data.
REQ-016 SHALL have port sign_flag  output  1  architectural sign status.

Function
REQ-017 SHALL accept a result when in_valid && in_ready at a rising edge.
REQ-018 SHALL implement states IDLE, WR1, WR2; all outputs registered.
REQ-019 SHALL, one cycle after accept, enter WR1 and drive wr_en=1, wr_addr=in_rd, wr_data=in_out.
REQ-020 SHALL classify op 3'b010 (mul) and 3'b011 (div) as dual-write; all other ops single-write.
REQ-021 SHALL, for dual-write, go WR1->WR2 and drive wr_en=1, wr_addr=R_REG, wr_data=in_r (captured value).
REQ-022 SHALL drive in_ready=0 only in WR1 of a dual-write op; 1 in all other states, allowing back-to-back accepts.
REQ-023 SHALL, on a new accept while in WR1 (single) or WR2, go to WR1 with the new result; with no accept, go to IDLE.
REQ-024 SHALL suppress wr_en (force 0) whenever the write address is 0; state sequencing unchanged.
REQ-025 SHALL update sign_flag to in_sign on every accept; hold otherwise.
REQ-026 SHALL drive wr_en=0 in IDLE; wr_addr/wr_data hold last value.
REQ-027 SHALL ignore in_op/in_rd/in_out/in_r/in_sign when not accepting.

Reset
REQ-028 SHALL, while rst=1 at an edge, set state=IDLE, wr_en=0, wr_addr=0, wr_data=0, sign_flag=0.
REQ-029 SHALL drive in_ready=1 during and after reset.
REQ-030 SHALL discard any pending WR2 write when rst asserts in WR1; no R write occurs.

Configuration
REQ-031 SHALL, with WB_FWD_EN defined, add ports fwd_raddr input RADDR_W, fwd_hit output 1, fwd_data output DATA_W.
REQ-032 SHALL, with WB_FWD_EN, combinationally assert fwd_hit when a write to fwd_raddr (nonzero) is driven this cycle or pending in WR2, with fwd_data the corresponding value; the WR1 write takes priority.
REQ-033 SHALL, without WB_FWD_EN, omit these ports and all forwarding logic.

Structure
REQ-034 SHALL place ALU op-code constants (ADD..UADD, 3'b000..3'b111) and the state enum in shared package alu_pkg.
REQ-035 SHALL isolate forwarding compare in sub-module alu_wb_fwd, instantiated only under WB_FWD_EN.

Verification
REQ-036 SHALL test: op 000, rd=3, out=4 -> next cycle wr_en=1, addr 3, data 4; in_ready stays 1.
REQ-037 SHALL test: op 010, rd=5, out=16'h0001, r=16'hFFFE -> cycle 1 addr 5 data 0001, in_ready=0; cycle 2 addr F data FFFE.
REQ-038 SHALL test: op 011, rd=2, out=4, r=1, then op 100 held valid -> second op accepted only after in_ready returns 1; writes 2<-4, F<-1, then second result, no gaps or losses.
REQ-039 SHALL test: op 101, rd=0 -> wr_en stays 0; sign_flag still updated.
REQ-040 SHALL test: rst asserted during WR1 of a mul -> next cycle wr_en=0, state IDLE, no write to F.
REQ-041 SHALL test (WB_FWD_EN): during WR2 of a div with r=1, fwd_raddr=F -> fwd_hit=1, fwd_data=1; fwd_raddr=0 -> fwd_hit=0.
